instruction_record_table: RTL and testbench
===========================================

Name: instruction_record_table

Overview:
- Producer side of the write-hazard record interface: allocates, tracks and retires per-instruction hazard records.
- Each record carries the vd, vs1 and vs2 register groups, gather flags and a per-element completion mask.
- Each record slot drives one per-record hazard checker in the lane, which compares a pending write against that record.
- Assigns the 3-bit instruction index. At most 4 instructions are in flight, so the index MSB-flip age compare in the checkers stays valid.

Parameters:
- ENTRIES, 4, number of record slots. Fixed at 4: slot = instIndex[1:0].
- MASK_W, 32, element-mask width per record.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous active-high reset
- alloc_valid  in  1  new instruction record offered
- alloc_ready  out  1  slot for next index is free
- alloc_vd_valid  in  1  instruction writes vd
- alloc_vd_bits  in  5  vd base register
- alloc_vs1_valid  in  1  instruction reads vs1
- alloc_vs1_bits  in  5  vs1 base register
- alloc_vs2  in  5  vs2 base register
- alloc_gather  in  1  gather-type read of vs2
- alloc_gather16  in  1  gather16 read of vs1
- alloc_onlyRead  in  1  instruction has no vd write-back
- alloc_instIndex  out  3  index that will be assigned on the current handshake
- progress_valid  in  1  element-group completion update
- progress_instIndex  in  3  target instruction
- progress_mask  in  MASK_W  bits to OR into elementMask
- retire_valid  in  1  instruction finished
- retire_instIndex  in  3  instruction to retire
- record_valid  out  4  per-slot valid
- record_vd_valid  out  4  per slot
- record_vd_bits  out  20  5 bits per slot, slot 0 in LSBs
- record_vs1_valid  out  4  per slot
- record_vs1_bits  out  20  5 bits per slot
- record_vs2  out  20  5 bits per slot
- record_instIndex  out  12  3 bits per slot
- record_gather  out  4  per slot
- record_gather16  out  4  per slot
- record_onlyRead  out  4  per slot
- record_elementMask  out  4*MASK_W  per slot; 1 = element done
- occupancy  out  3  number of valid slots, 0..4
- protocol_error  out  1  sticky error flag

Behaviour:
- Reset (async, immediate): all record_valid=0, all fields and masks=0, index counter=0, occupancy=0, protocol_error=0. alloc_ready=1 after reset.
- Index counter nextIdx:
  - 3 bits; alloc_instIndex=nextIdx.
  - Increments by 1 on an accepted alloc; wraps 7->0.
  - Target slot s=nextIdx[1:0].
- alloc_ready = ~record_valid[s], from registered state only. There is no bypass from a same-cycle retire.
- Accept (alloc_valid & alloc_ready) at the edge:
  - Slot s gets all fields, instIndex=nextIdx, elementMask=0, valid=1.
  - The record is visible on the outputs the next cycle (1-cycle latency).
- Progress:
  - Applies if record_valid[p[1:0]] and stored instIndex==progress_instIndex.
  - Then mask |= progress_mask at the edge.
  - Otherwise ignored and protocol_error set.
- Retire:
  - Applies if the slot is valid and the index matches. Then valid=0 next cycle; mask and fields hold their stale values.
  - Otherwise ignored and protocol_error set.
  - Out-of-order retire is allowed.
- Progress and retire to the same record in the same cycle: retire wins, mask update dropped, no error.
- Retire of slot s in the same cycle as alloc_valid targeting slot s: alloc not accepted this cycle; accepted the following cycle.
- Alloc, progress and retire may all occur in the same cycle on different slots; all take effect.
- occupancy: registered, equals popcount(record_valid). Updated for alloc and retire in the same edge (+1-1=0 change).
- protocol_error: cleared only by reset.
- Reset mid-operation drops all records with no handshake completion.

Test Plan:
- Reset then 4 allocs (vd=8,16,24,0) -> alloc_instIndex 0,1,2,3; record_valid=4'b1111; occupancy=4; alloc_ready=0.
- Full table, alloc_valid held, retire index 0 -> alloc_ready=1 only the cycle after; next alloc gets index 4 in slot 0 with mask 0.
- Progress idx 1 mask 0x0000000F, then 0x000000F0 -> slot 1 mask=0x000000FF; other masks unchanged.
- Same-cycle progress and retire to idx 2 -> record_valid[2]=0, protocol_error=0.
- Retire idx 5 while slot 1 holds idx 1 -> ignored, slot 1 still valid, protocol_error=1 and stays 1.
- Allocate and retire 9 instructions in sequence -> index wraps 7->0; slot = idx[1:0]; occupancy never exceeds 4; async reset mid-stream clears all outputs without a clock edge.

Source files
------------

// File: rtl/instruction_record_table.sv
// instruction_record_table: producer side of the write-hazard record interface.
// Allocates one record per in-flight instruction (slot = instIndex[1:0]),
// accumulates per-element completion and retires records on request.
// At most four instructions are live, so the 3-bit index age compare
// (MSB flip) done by the downstream hazard checkers stays unambiguous.
module instruction_record_table #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned MASK_W  = 32
) (
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic                       alloc_vd_valid,
    input  logic [4:0]                 alloc_vd_bits,
    input  logic                       alloc_vs1_valid,
    input  logic [4:0]                 alloc_vs1_bits,
    input  logic [4:0]                 alloc_vs2,
    input  logic                       alloc_gather,
    input  logic                       alloc_gather16,
    input  logic                       alloc_onlyRead,
    output logic [2:0]                 alloc_instIndex,

    input  logic                       progress_valid,
    input  logic [2:0]                 progress_instIndex,
    input  logic [MASK_W-1:0]          progress_mask,

    input  logic                       retire_valid,
    input  logic [2:0]                 retire_instIndex,

    output logic [ENTRIES-1:0]         record_valid,
    output logic [ENTRIES-1:0]         record_vd_valid,
    output logic [ENTRIES*5-1:0]       record_vd_bits,
    output logic [ENTRIES-1:0]         record_vs1_valid,
    output logic [ENTRIES*5-1:0]       record_vs1_bits,
    output logic [ENTRIES*5-1:0]       record_vs2,
    output logic [ENTRIES*3-1:0]       record_instIndex,
    output logic [ENTRIES-1:0]         record_gather,
    output logic [ENTRIES-1:0]         record_gather16,
    output logic [ENTRIES-1:0]         record_onlyRead,
    output logic [ENTRIES*MASK_W-1:0]  record_elementMask,
    output logic [2:0]                 occupancy,
    output logic                       protocol_error
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned SLOT_W = 2;
    localparam int unsigned OCC_W  = 3;

    // Static description of one in-flight instruction.
    typedef struct packed {
        logic             vd_valid;
        logic [REG_W-1:0] vd_bits;
        logic             vs1_valid;
        logic [REG_W-1:0] vs1_bits;
        logic [REG_W-1:0] vs2;
        logic [IDX_W-1:0] inst_idx;
        logic             gather;
        logic             gather16;
        logic             only_read;
    } rec_t;

    rec_t [ENTRIES-1:0]              rec_q, rec_d;
    logic [ENTRIES-1:0][MASK_W-1:0]  mask_q, mask_d;
    logic [ENTRIES-1:0]              valid_q, valid_d;
    logic [IDX_W-1:0]                next_idx_q, next_idx_d;
    logic [OCC_W-1:0]                occ_q, occ_d;
    logic                            err_q, err_d;

    logic [SLOT_W-1:0]               alloc_slot;
    logic [SLOT_W-1:0]               prog_slot;
    logic [SLOT_W-1:0]               ret_slot;
    logic                            alloc_fire;
    logic                            prog_hit;
    logic                            ret_hit;
    logic                            prog_apply;

    // Request decode: a request only hits a live record carrying the same index.
    always_comb begin
        alloc_slot = next_idx_q[SLOT_W-1:0];
        prog_slot  = progress_instIndex[SLOT_W-1:0];
        ret_slot   = retire_instIndex[SLOT_W-1:0];
        // Ready comes from registered state only; a same-cycle retire does not bypass.
        alloc_fire = alloc_valid & ~valid_q[alloc_slot];
        prog_hit   = progress_valid & valid_q[prog_slot]
                   & (rec_q[prog_slot].inst_idx == progress_instIndex);
        ret_hit    = retire_valid & valid_q[ret_slot]
                   & (rec_q[ret_slot].inst_idx == retire_instIndex);
        // Retire of the same record wins over its progress update.
        prog_apply = prog_hit & ~(ret_hit & (ret_slot == prog_slot));
    end

    // Next-state: progress, retire and alloc touch disjoint slots when all fire.
    always_comb begin
        rec_d      = rec_q;
        mask_d     = mask_q;
        valid_d    = valid_q;
        next_idx_d = next_idx_q;
        occ_d      = occ_q;
        err_d      = err_q;

        if (prog_apply) begin
            mask_d[prog_slot] = mask_q[prog_slot] | progress_mask;
        end

        // Retired records keep their fields and mask; only valid drops.
        if (ret_hit) begin
            valid_d[ret_slot] = 1'b0;
        end

        if (alloc_fire) begin
            rec_d[alloc_slot].vd_valid  = alloc_vd_valid;
            rec_d[alloc_slot].vd_bits   = alloc_vd_bits;
            rec_d[alloc_slot].vs1_valid = alloc_vs1_valid;
            rec_d[alloc_slot].vs1_bits  = alloc_vs1_bits;
            rec_d[alloc_slot].vs2       = alloc_vs2;
            rec_d[alloc_slot].inst_idx  = next_idx_q;
            rec_d[alloc_slot].gather    = alloc_gather;
            rec_d[alloc_slot].gather16  = alloc_gather16;
            rec_d[alloc_slot].only_read = alloc_onlyRead;
            mask_d[alloc_slot]          = '0;
            valid_d[alloc_slot]         = 1'b1;
            next_idx_d                  = next_idx_q + IDX_W'(1);
        end

        occ_d = occ_q + OCC_W'(alloc_fire) - OCC_W'(ret_hit);

        // Sticky: any progress or retire that names no live record.
        if ((progress_valid & ~prog_hit) | (retire_valid & ~ret_hit)) begin
            err_d = 1'b1;
        end
    end

    // State registers with immediate clear on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rec_q      <= '0;
            mask_q     <= '0;
            valid_q    <= '0;
            next_idx_q <= '0;
            occ_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rec_q      <= rec_d;
            mask_q     <= mask_d;
            valid_q    <= valid_d;
            next_idx_q <= next_idx_d;
            occ_q      <= occ_d;
            err_q      <= err_d;
        end
    end

    assign alloc_ready     = ~valid_q[alloc_slot];
    assign alloc_instIndex = next_idx_q;
    assign record_valid    = valid_q;
    assign occupancy       = occ_q;
    assign protocol_error  = err_q;

    // Flatten per-slot records onto the checker-facing buses, slot 0 in LSBs.
    for (genvar g = 0; g < ENTRIES; g++) begin : g_slot
        assign record_vd_valid[g]                      = rec_q[g].vd_valid;
        assign record_vd_bits[g*REG_W +: REG_W]        = rec_q[g].vd_bits;
        assign record_vs1_valid[g]                     = rec_q[g].vs1_valid;
        assign record_vs1_bits[g*REG_W +: REG_W]       = rec_q[g].vs1_bits;
        assign record_vs2[g*REG_W +: REG_W]            = rec_q[g].vs2;
        assign record_instIndex[g*IDX_W +: IDX_W]      = rec_q[g].inst_idx;
        assign record_gather[g]                        = rec_q[g].gather;
        assign record_gather16[g]                      = rec_q[g].gather16;
        assign record_onlyRead[g]                      = rec_q[g].only_read;
        assign record_elementMask[g*MASK_W +: MASK_W]  = mask_q[g];
    end

endmodule

// File: tb/tb_instruction_record_table.sv
// Bench for instruction_record_table: directed scenarios plus randomized
// traffic, all checked against a slot-array reference model.
module tb_instruction_record_table;

    logic         clock = 1'b0;
    logic         reset;
    logic         alloc_valid;
    logic         alloc_ready;
    logic         alloc_vd_valid;
    logic [4:0]   alloc_vd_bits;
    logic         alloc_vs1_valid;
    logic [4:0]   alloc_vs1_bits;
    logic [4:0]   alloc_vs2;
    logic         alloc_gather;
    logic         alloc_gather16;
    logic         alloc_onlyRead;
    logic [2:0]   alloc_instIndex;
    logic         progress_valid;
    logic [2:0]   progress_instIndex;
    logic [31:0]  progress_mask;
    logic         retire_valid;
    logic [2:0]   retire_instIndex;
    logic [3:0]   record_valid;
    logic [3:0]   record_vd_valid;
    logic [19:0]  record_vd_bits;
    logic [3:0]   record_vs1_valid;
    logic [19:0]  record_vs1_bits;
    logic [19:0]  record_vs2;
    logic [11:0]  record_instIndex;
    logic [3:0]   record_gather;
    logic [3:0]   record_gather16;
    logic [3:0]   record_onlyRead;
    logic [127:0] record_elementMask;
    logic [2:0]   occupancy;
    logic         protocol_error;

    instruction_record_table #(.ENTRIES(4), .MASK_W(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .alloc_valid        (alloc_valid),
        .alloc_ready        (alloc_ready),
        .alloc_vd_valid     (alloc_vd_valid),
        .alloc_vd_bits      (alloc_vd_bits),
        .alloc_vs1_valid    (alloc_vs1_valid),
        .alloc_vs1_bits     (alloc_vs1_bits),
        .alloc_vs2          (alloc_vs2),
        .alloc_gather       (alloc_gather),
        .alloc_gather16     (alloc_gather16),
        .alloc_onlyRead     (alloc_onlyRead),
        .alloc_instIndex    (alloc_instIndex),
        .progress_valid     (progress_valid),
        .progress_instIndex (progress_instIndex),
        .progress_mask      (progress_mask),
        .retire_valid       (retire_valid),
        .retire_instIndex   (retire_instIndex),
        .record_valid       (record_valid),
        .record_vd_valid    (record_vd_valid),
        .record_vd_bits     (record_vd_bits),
        .record_vs1_valid   (record_vs1_valid),
        .record_vs1_bits    (record_vs1_bits),
        .record_vs2         (record_vs2),
        .record_instIndex   (record_instIndex),
        .record_gather      (record_gather),
        .record_gather16    (record_gather16),
        .record_onlyRead    (record_onlyRead),
        .record_elementMask (record_elementMask),
        .occupancy          (occupancy),
        .protocol_error     (protocol_error)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: one entry per slot, plus the issue counter and error flag.
    bit          m_valid [4];
    bit          m_vdv   [4];
    logic [4:0]  m_vd    [4];
    bit          m_vs1v  [4];
    logic [4:0]  m_vs1   [4];
    logic [4:0]  m_vs2   [4];
    logic [2:0]  m_idx   [4];
    bit          m_g     [4];
    bit          m_g16   [4];
    bit          m_or    [4];
    logic [31:0] m_mask  [4];
    int          m_next;
    bit          m_err;

    // Expected bus images derived from the model.
    logic [3:0]   e_valid, e_vdv, e_vs1v, e_g, e_g16, e_or;
    logic [19:0]  e_vd, e_vs1, e_vs2;
    logic [11:0]  e_idx;
    logic [127:0] e_mask;
    logic [2:0]   e_occ;

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_valid[k] = 0; m_vdv[k] = 0; m_vd[k] = '0; m_vs1v[k] = 0;
            m_vs1[k] = '0; m_vs2[k] = '0; m_idx[k] = '0; m_g[k] = 0;
            m_g16[k] = 0; m_or[k] = 0; m_mask[k] = '0;
        end
        m_next = 0;
        m_err  = 0;
    endtask

    task automatic model_expect();
        int cnt;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            e_valid[k] = m_valid[k];
            e_vdv[k]   = m_vdv[k];
            e_vs1v[k]  = m_vs1v[k];
            e_g[k]     = m_g[k];
            e_g16[k]   = m_g16[k];
            e_or[k]    = m_or[k];
            e_vd[k*5 +: 5]     = m_vd[k];
            e_vs1[k*5 +: 5]    = m_vs1[k];
            e_vs2[k*5 +: 5]    = m_vs2[k];
            e_idx[k*3 +: 3]    = m_idx[k];
            e_mask[k*32 +: 32] = m_mask[k];
            if (m_valid[k]) cnt++;
        end
        e_occ = 3'(cnt);
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_vd_valid = 0; alloc_vd_bits = '0;
        alloc_vs1_valid = 0; alloc_vs1_bits = '0; alloc_vs2 = '0;
        alloc_gather = 0; alloc_gather16 = 0; alloc_onlyRead = 0;
        progress_valid = 0; progress_instIndex = '0; progress_mask = '0;
        retire_valid = 0; retire_instIndex = '0;
    endtask

    // One clock: the model decides from pre-edge state, then applies after the edge.
    task automatic step();
        int  s, ps, rs;
        bit  acc, p_ok, r_ok, bad;
        s    = m_next % 4;
        ps   = int'(progress_instIndex) % 4;
        rs   = int'(retire_instIndex) % 4;
        acc  = alloc_valid && !m_valid[s];
        p_ok = progress_valid && m_valid[ps] && (m_idx[ps] == progress_instIndex);
        r_ok = retire_valid && m_valid[rs] && (m_idx[rs] == retire_instIndex);
        bad  = (progress_valid && !p_ok) || (retire_valid && !r_ok);
        @(posedge clock);
        if (p_ok && !(r_ok && rs == ps)) m_mask[ps] = m_mask[ps] | progress_mask;
        if (r_ok) m_valid[rs] = 0;
        if (acc) begin
            m_valid[s] = 1; m_vdv[s] = alloc_vd_valid; m_vd[s] = alloc_vd_bits;
            m_vs1v[s] = alloc_vs1_valid; m_vs1[s] = alloc_vs1_bits; m_vs2[s] = alloc_vs2;
            m_idx[s] = 3'(m_next); m_g[s] = alloc_gather; m_g16[s] = alloc_gather16;
            m_or[s] = alloc_onlyRead; m_mask[s] = '0;
            m_next = (m_next + 1) % 8;
        end
        if (bad) m_err = 1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        model_reset();
        n_vec++; if (record_valid !== 4'b0000) begin n_err++; $display("FAIL reset_valid: got %b expected 0000", record_valid); end
        n_vec++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        n_vec++; if (alloc_ready !== 1'b1 || alloc_instIndex !== 3'd0) begin n_err++; $display("FAIL reset_alloc: got ready=%b idx=%0d expected ready=1 idx=0", alloc_ready, alloc_instIndex); end
        n_vec++; if (protocol_error !== 1'b0 || record_elementMask !== 128'd0) begin n_err++; $display("FAIL reset_err_mask: got err=%b mask=%h expected 0", protocol_error, record_elementMask); end
    endtask

    task automatic test_fill();
        logic [4:0] vds [4];
        vds[0] = 5'd8; vds[1] = 5'd16; vds[2] = 5'd24; vds[3] = 5'd0;
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            alloc_valid = 1; alloc_vd_valid = 1; alloc_vd_bits = vds[i];
            n_vec++; if (alloc_instIndex !== 3'(i)) begin n_err++; $display("FAIL fill_index%0d: got %0d expected %0d", i, alloc_instIndex, i); end
            step();
        end
        idle_inputs();
        n_vec++; if (record_valid !== 4'b1111) begin n_err++; $display("FAIL fill_valid: got %b expected 1111", record_valid); end
        n_vec++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL fill_occ: got %0d expected 4", occupancy); end
        n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b expected 0", alloc_ready); end
        n_vec++; if (record_vd_bits !== {5'd0, 5'd24, 5'd16, 5'd8}) begin n_err++; $display("FAIL fill_vd: got %h expected %h", record_vd_bits, {5'd0, 5'd24, 5'd16, 5'd8}); end
    endtask

    task automatic test_retire_refill();
        idle_inputs();
        progress_valid = 1; progress_instIndex = 3'd0; progress_mask = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        n_vec++; if (record_elementMask[31:0] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL refill_premask: got %h expected deadbeef", record_elementMask[31:0]); end
        alloc_valid = 1; alloc_vd_valid = 1; alloc_vd_bits = 5'd9;
        step();
        n_vec++; if (record_valid !== 4'b1111 || alloc_instIndex !== 3'd4) begin n_err++; $display("FAIL refill_blocked: got valid=%b idx=%0d expected 1111 idx=4", record_valid, alloc_instIndex); end
        retire_valid = 1; retire_instIndex = 3'd0;
        n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL refill_no_bypass: got ready=%b expected 0", alloc_ready); end
        step();
        retire_valid = 0;
        n_vec++; if (record_valid !== 4'b1110 || alloc_ready !== 1'b1 || occupancy !== 3'd3) begin n_err++; $display("FAIL refill_retired: got valid=%b ready=%b occ=%0d expected 1110 1 3", record_valid, alloc_ready, occupancy); end
        step();
        idle_inputs();
        n_vec++; if (record_valid !== 4'b1111 || record_instIndex[2:0] !== 3'd4) begin n_err++; $display("FAIL refill_slot0: got valid=%b idx=%0d expected 1111 idx=4", record_valid, record_instIndex[2:0]); end
        n_vec++; if (record_elementMask[31:0] !== 32'd0 || record_vd_bits[4:0] !== 5'd9) begin n_err++; $display("FAIL refill_fields: got mask=%h vd=%0d expected 0 vd=9", record_elementMask[31:0], record_vd_bits[4:0]); end
    endtask

    task automatic test_progress();
        idle_inputs();
        progress_valid = 1; progress_instIndex = 3'd1; progress_mask = 32'h0000_000F;
        step();
        progress_mask = 32'h0000_00F0;
        step();
        idle_inputs();
        n_vec++; if (record_elementMask[63:32] !== 32'h0000_00FF) begin n_err++; $display("FAIL progress_slot1: got %h expected 000000ff", record_elementMask[63:32]); end
        n_vec++; if (record_elementMask[31:0] !== 32'd0 || record_elementMask[127:64] !== 64'd0) begin n_err++; $display("FAIL progress_others: got %h expected only slot1 set", record_elementMask); end
        n_vec++; if (protocol_error !== 1'b0) begin n_err++; $display("FAIL progress_err: got %b expected 0", protocol_error); end
    endtask

    task automatic test_prog_retire_same();
        idle_inputs();
        progress_valid = 1; progress_instIndex = 3'd2; progress_mask = 32'hFFFF_FFFF;
        retire_valid = 1; retire_instIndex = 3'd2;
        step();
        idle_inputs();
        n_vec++; if (record_valid[2] !== 1'b0 || protocol_error !== 1'b0) begin n_err++; $display("FAIL same_cycle: got valid2=%b err=%b expected 0 0", record_valid[2], protocol_error); end
        n_vec++; if (record_elementMask[95:64] !== 32'd0) begin n_err++; $display("FAIL same_cycle_mask: got %h expected 0", record_elementMask[95:64]); end
    endtask

    task automatic test_bad_retire();
        idle_inputs();
        retire_valid = 1; retire_instIndex = 3'd5;
        step();
        idle_inputs();
        n_vec++; if (record_valid !== 4'b1011 || protocol_error !== 1'b1) begin n_err++; $display("FAIL bad_retire: got valid=%b err=%b expected 1011 1", record_valid, protocol_error); end
        step(); step();
        n_vec++; if (protocol_error !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", protocol_error); end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        n_vec++; if (record_valid === 4'b0000) begin n_err++; $display("FAIL async_pre: got valid=%b expected nonzero", record_valid); end
        #1 reset = 1;
        #2;
        n_vec++; if (record_valid !== 4'b0000 || occupancy !== 3'd0 || protocol_error !== 1'b0) begin n_err++; $display("FAIL async_reset: got valid=%b occ=%0d err=%b expected 0 0 0", record_valid, occupancy, protocol_error); end
        n_vec++; if (alloc_instIndex !== 3'd0 || alloc_ready !== 1'b1 || record_elementMask !== 128'd0 || record_vd_bits !== 20'd0) begin n_err++; $display("FAIL async_fields: got idx=%0d ready=%b mask=%h vd=%h expected cleared", alloc_instIndex, alloc_ready, record_elementMask, record_vd_bits); end
        reset = 0;
        model_reset();
        @(posedge clock); #1;
    endtask

    task automatic test_wrap();
        int s;
        for (int i = 0; i < 9; i++) begin
            s = i % 4;
            idle_inputs();
            alloc_valid = 1; alloc_vd_valid = 1; alloc_vd_bits = 5'(i);
            n_vec++; if (alloc_instIndex !== 3'(i % 8) || alloc_ready !== 1'b1) begin n_err++; $display("FAIL wrap_offer%0d: got idx=%0d ready=%b expected %0d 1", i, alloc_instIndex, alloc_ready, i % 8); end
            step();
            idle_inputs();
            n_vec++; if (record_valid[s] !== 1'b1 || record_instIndex[s*3 +: 3] !== 3'(i % 8) || occupancy !== 3'd1) begin n_err++; $display("FAIL wrap_alloc%0d: got valid=%b idx=%0d occ=%0d expected slot %0d idx %0d occ 1", i, record_valid, record_instIndex[s*3 +: 3], occupancy, s, i % 8); end
            retire_valid = 1; retire_instIndex = 3'(i % 8);
            step();
            idle_inputs();
            n_vec++; if (record_valid !== 4'b0000 || occupancy !== 3'd0) begin n_err++; $display("FAIL wrap_retire%0d: got valid=%b occ=%0d expected 0 0", i, record_valid, occupancy); end
        end
    endtask

    task automatic test_random();
        int k;
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            alloc_valid     = ($urandom_range(0, 1) == 1);
            alloc_vd_valid  = 1'($urandom);
            alloc_vd_bits   = 5'($urandom);
            alloc_vs1_valid = 1'($urandom);
            alloc_vs1_bits  = 5'($urandom);
            alloc_vs2       = 5'($urandom);
            alloc_gather    = 1'($urandom);
            alloc_gather16  = 1'($urandom);
            alloc_onlyRead  = 1'($urandom);
            if ($urandom_range(0, 2) != 0) begin
                progress_valid = 1;
                k = $urandom_range(0, 3);
                progress_instIndex = ($urandom_range(0, 9) != 0) ? m_idx[k] : 3'($urandom);
                progress_mask = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                retire_valid = 1;
                k = $urandom_range(0, 3);
                retire_instIndex = ($urandom_range(0, 9) != 0) ? m_idx[k] : 3'($urandom);
            end
            n_vec++; if (alloc_ready !== !m_valid[m_next % 4] || alloc_instIndex !== 3'(m_next)) begin n_err++; $display("FAIL rand_offer%0d: got ready=%b idx=%0d expected %b %0d", c, alloc_ready, alloc_instIndex, !m_valid[m_next % 4], m_next); end
            step();
            model_expect();
            n_vec++; if (record_valid !== e_valid || occupancy !== e_occ || protocol_error !== m_err) begin n_err++; $display("FAIL rand_state%0d: got valid=%b occ=%0d err=%b expected %b %0d %b", c, record_valid, occupancy, protocol_error, e_valid, e_occ, m_err); end
            n_vec++; if (record_elementMask !== e_mask) begin n_err++; $display("FAIL rand_mask%0d: got %h expected %h", c, record_elementMask, e_mask); end
            n_vec++; if ({record_vd_valid, record_vd_bits, record_vs1_valid, record_vs1_bits, record_vs2, record_instIndex, record_gather, record_gather16, record_onlyRead}
                         !== {e_vdv, e_vd, e_vs1v, e_vs1, e_vs2, e_idx, e_g, e_g16, e_or}) begin
                n_err++; $display("FAIL rand_fields%0d: got vd=%h vs1=%h vs2=%h idx=%h expected vd=%h vs1=%h vs2=%h idx=%h", c, record_vd_bits, record_vs1_bits, record_vs2, record_instIndex, e_vd, e_vs1, e_vs2, e_idx);
            end
            n_vec++; if (occupancy > 3'd4) begin n_err++; $display("FAIL rand_occ_bound%0d: got %0d expected <=4", c, occupancy); end
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        model_reset();
        #2;
        test_reset();
        test_fill();
        test_retire_refill();
        test_progress();
        test_prog_retire_same();
        test_bad_retire();
        test_async_reset();
        test_wrap();
        test_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
